fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode stage that feeds the ID/EX register.
- Owns the PC and issues requests to instruction memory with a ready handshake.
- Latches the fetched instruction, its PC and PC+4 into the ID-side outputs.
- Honours hazard-unit stalls and branch-taken flushes.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/if_id_reg.sv | 50 +++++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and its pipeline register.
package cpu_pkg;

    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR   = 32'hE1A0_0000;  // MOV r0,r0
    localparam logic [31:0] PC_INC      = 32'd4;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load-enable, flush-to-bubble and synchronous active-low reset.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_W    = DEF_PC_W,
    parameter int unsigned          INSTR_W = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0]   NOP     = INSTR_W'(NOP_INSTR)
) (
    input  logic               clk,
    input  logic               R,
    input  logic               load_en,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [PC_W-1:0]    next_pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [PC_W-1:0]    next_pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    next_pc_q;
    logic               valid_q;

    // Flush only turns the slot into a bubble; the PC fields keep their last values.
    always_ff @(posedge clk) begin
        if (!R) begin
            instr_q   <= NOP;
            pc_q      <= '0;
            next_pc_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush) begin
            instr_q   <= NOP;
            valid_q   <= 1'b0;
        end else if (load_en) begin
            instr_q   <= instr_i;
            pc_q      <= pc_i;
            next_pc_q <= next_pc_i;
            valid_q   <= 1'b1;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign next_pc_o = next_pc_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem request handshake and feeds the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned        PC_W     = DEF_PC_W,
    parameter int unsigned        INSTR_W  = DEF_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = INSTR_W'(NOP_INSTR)
) (
    input  logic               clk,
    input  logic               R,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               hz_stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic [INSTR_W-1:0] ID_instr,
    output logic [PC_W-1:0]    ID_pc,
    output logic [PC_W-1:0]    ID_next_pc,
    output logic               ID_valid
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] INC        = PC_W'(PC_INC);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;
    logic            accept;

    always_ff @(posedge clk) begin
        if (!R) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC & ALIGN_MASK;
            req_addr_q <= RESET_PC & ALIGN_MASK;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        accept     = 1'b0;

        if (state_q == StFetch) begin
            req_addr_d = pc_q;
        end

        if (br_taken) begin
            pc_d = br_target & ALIGN_MASK;
            unique case (state_q)
                StFetch: state_d = StFetch;
                StWait:  state_d = imem_ready ? StFetch : StDrain;
                StDrain: state_d = StDrain;
                default: state_d = StFetch;
            endcase
        end else if (hz_stall) begin
            // A stalled response is dropped and the same PC is requested again.
            if (state_q == StDrain) begin
                state_d = imem_ready ? StFetch : StDrain;
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch, StWait: begin
                    if (imem_ready) begin
                        accept  = 1'b1;
                        pc_d    = pc_q + INC;
                        state_d = StFetch;
                    end else begin
                        state_d = StWait;
                    end
                end
                StDrain: state_d = imem_ready ? StFetch : StDrain;
                default: state_d = StFetch;
            endcase
        end
    end

    assign imem_req  = 1'b1;
    assign imem_addr = (state_q == StFetch) ? pc_q : req_addr_q;

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .NOP     (NOP)
    ) u_if_id_reg (
        .clk       (clk),
        .R         (R),
        .load_en   (~hz_stall),
        .flush     (br_taken | (~hz_stall & ~accept)),
        .instr_i   (imem_rdata),
        .pc_i      (imem_addr),
        .next_pc_i (pc_q + INC),
        .instr_o   (ID_instr),
        .pc_o      (ID_pc),
        .next_pc_o (ID_next_pc),
        .valid_o   (ID_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random run against a request-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP_C = 32'hE1A0_0000;

    logic        clk;
    logic        R;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        hz_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] ID_instr;
    logic [31:0] ID_pc;
    logic [31:0] ID_next_pc;
    logic        ID_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: PC, address of the request in flight, and whether that request is to be thrown away.
    logic [31:0] m_pc, m_held, m_instr, m_idpc, m_idnext;
    logic        m_busy, m_stale, m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    fetch_stage u_dut (
        .clk        (clk),
        .R          (R),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .hz_stall   (hz_stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .ID_instr   (ID_instr),
        .ID_pc      (ID_pc),
        .ID_next_pc (ID_next_pc),
        .ID_valid   (ID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_addr();
        return m_busy ? m_held : m_pc;
    endfunction

    // Drive one cycle of inputs, advance the model by the same cycle, and step past the edge.
    task automatic step(input logic r, input logic rdy, input logic stl, input logic br,
                        input logic [31:0] tgt);
        logic [31:0] a;
        R = r; imem_ready = rdy; hz_stall = stl; br_taken = br; br_target = tgt;
        a = model_addr();
        if (!r) begin
            m_pc = 32'h0; m_held = 32'h0; m_busy = 1'b0; m_stale = 1'b0;
            m_instr = NOP_C; m_idpc = 32'h0; m_idnext = 32'h0; m_valid = 1'b0;
        end else begin
            m_held = a;
            if (br) begin
                m_pc = {tgt[31:2], 2'b00};
                m_instr = NOP_C; m_valid = 1'b0;
                if (!m_stale) begin
                    m_stale = m_busy && !rdy;
                    m_busy  = m_stale;
                end
            end else if (stl) begin
                if (!m_stale || rdy) begin
                    m_busy = 1'b0; m_stale = 1'b0;
                end
            end else if (m_stale) begin
                m_instr = NOP_C; m_valid = 1'b0;
                if (rdy) begin
                    m_busy = 1'b0; m_stale = 1'b0;
                end
            end else if (rdy) begin
                m_instr = mem_word(a); m_idpc = a; m_idnext = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_busy = 1'b0;
            end else begin
                m_instr = NOP_C; m_valid = 1'b0; m_busy = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0F00);
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
        n_cmp++; if (ID_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ID_valid); end
        n_cmp++; if (ID_instr !== NOP_C) begin n_bad++; $display("FAIL reset_instr: got %h want %h", ID_instr, NOP_C); end
        n_cmp++; if (ID_pc !== 32'h0 || ID_next_pc !== 32'h0) begin
            n_bad++; $display("FAIL reset_pc: got %h/%h want 0/0", ID_pc, ID_next_pc);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (imem_addr !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_addr: got %h want %h", imem_addr, 32'(4 * i)); end
            n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL stream_req: got %b want 1", imem_req); end
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            n_cmp++; if (ID_valid !== 1'b1 || ID_instr !== mem_word(32'(4 * i))) begin
                n_bad++; $display("FAIL stream_instr: got %b/%h want 1/%h", ID_valid, ID_instr, mem_word(32'(4 * i)));
            end
            n_cmp++; if (ID_pc !== 32'(4 * i) || ID_next_pc !== 32'(4 * i + 4)) begin
                n_bad++; $display("FAIL stream_pc: got %h/%h want %h/%h", ID_pc, ID_next_pc, 32'(4 * i), 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_wait();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL wait_addr: got %h want 10", imem_addr); end
            n_cmp++; if (ID_valid !== 1'b0 || ID_instr !== NOP_C) begin
                n_bad++; $display("FAIL wait_bubble: got %b/%h want 0/%h", ID_valid, ID_instr, NOP_C);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (ID_valid !== 1'b1 || ID_instr !== mem_word(32'h10) || ID_pc !== 32'h10) begin
            n_bad++; $display("FAIL wait_accept: got %b/%h/%h want 1/%h/10", ID_valid, ID_instr, ID_pc, mem_word(32'h10));
        end
        n_cmp++; if (imem_addr !== 32'h14) begin n_bad++; $display("FAIL wait_next: got %h want 14", imem_addr); end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            n_cmp++; if (ID_valid !== 1'b1 || ID_pc !== 32'h14 || ID_instr !== mem_word(32'h14)) begin
                n_bad++; $display("FAIL stall_hold: got %b/%h/%h want 1/14/%h", ID_valid, ID_pc, ID_instr, mem_word(32'h14));
            end
            n_cmp++; if (imem_addr !== 32'h18) begin n_bad++; $display("FAIL stall_pc: got %h want 18", imem_addr); end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (ID_valid !== 1'b1 || ID_pc !== 32'h18 || ID_instr !== mem_word(32'h18)) begin
            n_bad++; $display("FAIL stall_release: got %b/%h/%h want 1/18/%h", ID_valid, ID_pc, ID_instr, mem_word(32'h18));
        end
    endtask

    task automatic test_branch_fetch();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL brf_addr: got %h want 100", imem_addr); end
        n_cmp++; if (ID_valid !== 1'b0 || ID_instr !== NOP_C) begin
            n_bad++; $display("FAIL brf_flush: got %b/%h want 0/%h", ID_valid, ID_instr, NOP_C);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (ID_valid !== 1'b1 || ID_pc !== 32'h100) begin
            n_bad++; $display("FAIL brf_target: got %b/%h want 1/100", ID_valid, ID_pc);
        end
    endtask

    task automatic test_branch_wait();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (imem_addr !== 32'h40 || ID_valid !== 1'b0) begin
                n_bad++; $display("FAIL brw_hold: got %h/%b want 40/0", imem_addr, ID_valid);
            end
            step(1'b1, (i == 1), 1'b0, 1'b0, 32'h0);
        end
        n_cmp++; if (ID_valid !== 1'b0 || imem_addr !== 32'h200) begin
            n_bad++; $display("FAIL brw_drain: got %b/%h want 0/200", ID_valid, imem_addr);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (ID_valid !== 1'b1 || ID_pc !== 32'h200 || ID_instr !== mem_word(32'h200)) begin
            n_bad++; $display("FAIL brw_target: got %b/%h/%h want 1/200/%h", ID_valid, ID_pc, ID_instr, mem_word(32'h200));
        end
    endtask

    task automatic test_wrap_and_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (ID_pc !== 32'hFFFF_FFFC || ID_next_pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_bad++; $display("FAIL wrap: got %h/%h/%h want fffffffc/0/0", ID_pc, ID_next_pc, imem_addr);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL rst_wait_pre: got %h want 4", imem_addr); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        n_cmp++; if (imem_addr !== 32'h0 || ID_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_wait: got %h/%b want 0/0", imem_addr, ID_valid);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] exp_addr;
        for (int i = 0; i < 3000; i++) begin
            exp_addr = model_addr();
            if (imem_addr !== exp_addr || imem_req !== 1'b1) begin
                n_bad++; $display("FAIL rnd_addr@%0d: got %h/%b want %h/1", i, imem_addr, imem_req, exp_addr);
            end
            n_cmp++;
            step(($urandom_range(99, 0) >= 2), ($urandom_range(99, 0) < 65),
                 ($urandom_range(99, 0) < 15), ($urandom_range(99, 0) < 10), $urandom);
            n_cmp++;
            if (ID_valid !== m_valid || ID_instr !== m_instr) begin
                n_bad++; $display("FAIL rnd_id@%0d: got %b/%h want %b/%h", i, ID_valid, ID_instr, m_valid, m_instr);
            end
            if (m_valid) begin
                n_cmp++;
                if (ID_pc !== m_idpc || ID_next_pc !== m_idnext) begin
                    n_bad++; $display("FAIL rnd_pc@%0d: got %h/%h want %h/%h", i, ID_pc, ID_next_pc, m_idpc, m_idnext);
                end
            end
        end
    endtask

    initial begin
        R = 1'b0; imem_ready = 1'b0; hz_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        m_pc = 32'h0; m_held = 32'h0; m_busy = 1'b0; m_stale = 1'b0;
        m_instr = NOP_C; m_idpc = 32'h0; m_idnext = 32'h0; m_valid = 1'b0;
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_branch_fetch();
        test_branch_wait();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
